// File: rtl/alu_pkg.sv
`default_nettype none
// ============================================================================
// alu_pkg : ALU control codes and forwarding selects shared by ALU decoder/EX.
// Revision: 1.0
// ============================================================================
package alu_pkg;

  localparam logic [3:0] ALU_AND = 4'd0;
  localparam logic [3:0] ALU_OR  = 4'd1;
  localparam logic [3:0] ALU_ADD = 4'd2;
  localparam logic [3:0] ALU_LUI = 4'd4;
  localparam logic [3:0] ALU_SUB = 4'd6;
  localparam logic [3:0] ALU_SLT = 4'd7;
  localparam logic [3:0] ALU_NOR = 4'd12;
  localparam logic [3:0] ALU_BAD = 4'd15;

  localparam logic [1:0] FWD_REG   = 2'd0;
  localparam logic [1:0] FWD_MEMWB = 2'd1;
  localparam logic [1:0] FWD_EXMEM = 2'd2;

endpackage
`default_nettype wire

// File: rtl/alu_core.sv
`default_nettype none
// ============================================================================
// alu_core : combinational ALU producing result, zero, overflow, illegal.
// Revision: 1.0
// ============================================================================
module alu_core
  import alu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  input  logic [3:0]       aluctrl_i,
  output logic [WIDTH-1:0] result_o,
  output logic             zero_o,
  output logic             overflow_o,
  output logic             illegal_o
);

  logic [WIDTH-1:0] w_sum;
  logic [WIDTH-1:0] w_diff;
  logic             w_slt;

  assign w_sum  = a_i + b_i;
  assign w_diff = a_i - b_i;
  assign w_slt  = $signed(a_i) < $signed(b_i);

  always_comb begin
    result_o   = '0;
    overflow_o = 1'b0;
    illegal_o  = 1'b0;
    case (aluctrl_i)
      ALU_AND: result_o = a_i & b_i;
      ALU_OR:  result_o = a_i | b_i;
      ALU_ADD: begin
        result_o   = w_sum;
        overflow_o = (a_i[WIDTH-1] == b_i[WIDTH-1]) && (w_sum[WIDTH-1] != a_i[WIDTH-1]);
      end
      ALU_LUI: result_o = b_i << 16;
      // Subtraction adds ~B, so overflow needs the operand signs to differ.
      ALU_SUB: begin
        result_o   = w_diff;
        overflow_o = (a_i[WIDTH-1] != b_i[WIDTH-1]) && (w_diff[WIDTH-1] != a_i[WIDTH-1]);
      end
      ALU_SLT: result_o = {{(WIDTH-1){1'b0}}, w_slt};
      ALU_NOR: result_o = ~(a_i | b_i);
      default: illegal_o = 1'b1;
    endcase
  end

  assign zero_o = (result_o == '0);

endmodule
`default_nettype wire

// File: rtl/alu_ex_stage.sv
`default_nettype none
// ============================================================================
// alu_ex_stage : EX stage with operand forwarding, ALU and EX/MEM register.
// Revision: 1.0
// ============================================================================
module alu_ex_stage
  import alu_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int REGW  = 5
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  input  logic             stall,
  input  logic             flush,
  input  logic [3:0]       aluctrl,
  input  logic [WIDTH-1:0] a_val,
  input  logic [WIDTH-1:0] b_val,
  input  logic [WIDTH-1:0] imm,
  input  logic             alusrc,
  input  logic [1:0]       fwd_a,
  input  logic [1:0]       fwd_b,
  input  logic [WIDTH-1:0] exmem_data,
  input  logic [WIDTH-1:0] memwb_data,
  input  logic [REGW-1:0]  dest_in,
  input  logic             regwrite_in,
  input  logic             memread_in,
  input  logic             memwrite_in,
  output logic             out_valid,
  output logic [WIDTH-1:0] result,
  output logic [WIDTH-1:0] store_data,
  output logic             zero,
  output logic             overflow,
  output logic             illegal,
  output logic [REGW-1:0]  dest_out,
  output logic             regwrite_out,
  output logic             memread_out,
  output logic             memwrite_out
);

  logic [WIDTH-1:0] w_op_a;
  logic [WIDTH-1:0] w_fwd_b;
  logic [WIDTH-1:0] w_op_b;
  logic [WIDTH-1:0] w_alu_result;
  logic             w_alu_zero;
  logic             w_alu_ovf;
  logic             w_alu_ill;
  logic             w_squash;

  always_comb begin
    case (fwd_a)
      FWD_MEMWB: w_op_a = memwb_data;
      FWD_EXMEM: w_op_a = exmem_data;
      default:   w_op_a = a_val;
    endcase
    case (fwd_b)
      FWD_MEMWB: w_fwd_b = memwb_data;
      FWD_EXMEM: w_fwd_b = exmem_data;
      default:   w_fwd_b = b_val;
    endcase
  end

  assign w_op_b = alusrc ? imm : w_fwd_b;

  alu_core #(
    .WIDTH (WIDTH)
  ) u_alu_core (
    .a_i        (w_op_a),
    .b_i        (w_op_b),
    .aluctrl_i  (aluctrl),
    .result_o   (w_alu_result),
    .zero_o     (w_alu_zero),
    .overflow_o (w_alu_ovf),
    .illegal_o  (w_alu_ill)
  );

  // A faulting instruction still reaches EX/MEM but must not commit state.
  assign w_squash = w_alu_ovf | w_alu_ill;

  logic             valid_q,    valid_d;
  logic [WIDTH-1:0] result_q,   result_d;
  logic [WIDTH-1:0] store_q,    store_d;
  logic             zero_q,     zero_d;
  logic             ovf_q,      ovf_d;
  logic             ill_q,      ill_d;
  logic [REGW-1:0]  dest_q,     dest_d;
  logic             regwr_q,    regwr_d;
  logic             memrd_q,    memrd_d;
  logic             memwr_q,    memwr_d;

  always_comb begin
    valid_d  = valid_q;
    result_d = result_q;
    store_d  = store_q;
    zero_d   = zero_q;
    ovf_d    = ovf_q;
    ill_d    = ill_q;
    dest_d   = dest_q;
    regwr_d  = regwr_q;
    memrd_d  = memrd_q;
    memwr_d  = memwr_q;
    if (flush || (!stall && !in_valid)) begin
      valid_d  = 1'b0;
      result_d = '0;
      store_d  = '0;
      zero_d   = 1'b0;
      ovf_d    = 1'b0;
      ill_d    = 1'b0;
      dest_d   = '0;
      regwr_d  = 1'b0;
      memrd_d  = 1'b0;
      memwr_d  = 1'b0;
    end else if (!stall) begin
      valid_d  = 1'b1;
      result_d = w_alu_result;
      store_d  = w_fwd_b;
      zero_d   = w_alu_zero;
      ovf_d    = w_alu_ovf;
      ill_d    = w_alu_ill;
      dest_d   = dest_in;
      regwr_d  = regwrite_in & ~w_squash;
      memrd_d  = memread_in;
      memwr_d  = memwrite_in & ~w_squash;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      valid_q  <= 1'b0;
      result_q <= '0;
      store_q  <= '0;
      zero_q   <= 1'b0;
      ovf_q    <= 1'b0;
      ill_q    <= 1'b0;
      dest_q   <= '0;
      regwr_q  <= 1'b0;
      memrd_q  <= 1'b0;
      memwr_q  <= 1'b0;
    end else begin
      valid_q  <= valid_d;
      result_q <= result_d;
      store_q  <= store_d;
      zero_q   <= zero_d;
      ovf_q    <= ovf_d;
      ill_q    <= ill_d;
      dest_q   <= dest_d;
      regwr_q  <= regwr_d;
      memrd_q  <= memrd_d;
      memwr_q  <= memwr_d;
    end
  end

  assign out_valid    = valid_q;
  assign result       = result_q;
  assign store_data   = store_q;
  assign zero         = zero_q;
  assign overflow     = ovf_q;
  assign illegal      = ill_q;
  assign dest_out     = dest_q;
  assign regwrite_out = regwr_q;
  assign memread_out  = memrd_q;
  assign memwrite_out = memwr_q;

endmodule
`default_nettype wire

// File: tb/tb_alu_ex_stage.sv
`default_nettype none
// ============================================================================
// tb_alu_ex_stage : directed and randomized checks against a behavioural model.
// Revision: 1.0
// ============================================================================
module tb_alu_ex_stage;

  logic        clk = 1'b0;
  logic        reset, in_valid, stall, flush, alusrc;
  logic [3:0]  aluctrl;
  logic [31:0] a_val, b_val, imm, exmem_data, memwb_data;
  logic [1:0]  fwd_a, fwd_b;
  logic [4:0]  dest_in;
  logic        regwrite_in, memread_in, memwrite_in;
  logic        out_valid, zero, overflow, illegal;
  logic [31:0] result, store_data;
  logic [4:0]  dest_out;
  logic        regwrite_out, memread_out, memwrite_out;

  int checks = 0;
  int errors = 0;

  typedef struct packed {
    logic        v;
    logic [31:0] res;
    logic [31:0] sd;
    logic        z;
    logic        ov;
    logic        ill;
    logic [4:0]  dest;
    logic        rw;
    logic        mr;
    logic        mw;
  } exp_t;

  exp_t exp_q = '0;
  exp_t obs;

  localparam longint SMAX = 64'sd2147483647;
  localparam longint SMIN = -SMAX - 1;

  always #5 clk = ~clk;

  alu_ex_stage #(.WIDTH(32), .REGW(5)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .stall(stall), .flush(flush),
    .aluctrl(aluctrl), .a_val(a_val), .b_val(b_val), .imm(imm), .alusrc(alusrc),
    .fwd_a(fwd_a), .fwd_b(fwd_b), .exmem_data(exmem_data), .memwb_data(memwb_data),
    .dest_in(dest_in), .regwrite_in(regwrite_in), .memread_in(memread_in),
    .memwrite_in(memwrite_in), .out_valid(out_valid), .result(result),
    .store_data(store_data), .zero(zero), .overflow(overflow), .illegal(illegal),
    .dest_out(dest_out), .regwrite_out(regwrite_out), .memread_out(memread_out),
    .memwrite_out(memwrite_out)
  );

  always_comb obs = {out_valid, result, store_data, zero, overflow, illegal,
                     dest_out, regwrite_out, memread_out, memwrite_out};

  function automatic logic [31:0] pick(input logic [1:0] sel, input logic [31:0] reg_v);
    if (sel == 2'd1) return memwb_data;
    if (sel == 2'd2) return exmem_data;
    return reg_v;
  endfunction

  // Next EX/MEM contents from the current inputs, using signed integer arithmetic.
  function automatic exp_t model_next(input exp_t cur);
    exp_t n;
    logic [31:0] a, fb, b, r;
    longint s;
    logic ov, il;
    if (reset || flush) return '0;
    if (stall) return cur;
    if (!in_valid) return '0;
    a  = pick(fwd_a, a_val);
    fb = pick(fwd_b, b_val);
    b  = alusrc ? imm : fb;
    ov = 1'b0;
    il = 1'b0;
    r  = 32'd0;
    case (aluctrl)
      4'd0:  r = a & b;
      4'd1:  r = a | b;
      4'd2:  begin s = longint'($signed(a)) + longint'($signed(b)); r = s[31:0]; ov = (s > SMAX) || (s < SMIN); end
      4'd4:  r = b * 32'd65536;
      4'd6:  begin s = longint'($signed(a)) - longint'($signed(b)); r = s[31:0]; ov = (s > SMAX) || (s < SMIN); end
      4'd7:  r = (longint'($signed(a)) < longint'($signed(b))) ? 32'd1 : 32'd0;
      4'd12: r = ~(a | b);
      default: il = 1'b1;
    endcase
    n.v    = 1'b1;
    n.res  = r;
    n.sd   = fb;
    n.z    = (r == 32'd0);
    n.ov   = ov;
    n.ill  = il;
    n.dest = dest_in;
    n.rw   = regwrite_in && !ov && !il;
    n.mr   = memread_in;
    n.mw   = memwrite_in && !ov && !il;
    return n;
  endfunction

  task automatic step();
    exp_q = model_next(exp_q);
    @(posedge clk);
    #1;
  endtask

  task automatic drive_op(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    reset = 1'b0; in_valid = 1'b1; stall = 1'b0; flush = 1'b0;
    aluctrl = op; a_val = a; b_val = b; imm = $urandom; alusrc = 1'b0;
    fwd_a = 2'd0; fwd_b = 2'd0; exmem_data = $urandom; memwb_data = $urandom;
    dest_in = 5'($urandom); regwrite_in = 1'b1; memread_in = 1'b0; memwrite_in = 1'b0;
  endtask

  task automatic test_reset();
    drive_op(4'($urandom), $urandom, $urandom);
    reset = 1'b1; memread_in = 1'b1; memwrite_in = 1'b1;
    step();
    checks++;
    if (obs !== 76'd0) begin
      errors++; $display("FAIL reset_outputs: got %h expected 0", obs);
    end
    drive_op(4'd2, 32'd5, 32'd7);
    step();
    checks++;
    if (result !== 32'd12 || zero !== 1'b0 || out_valid !== 1'b1) begin
      errors++; $display("FAIL reset_then_add: result=%0d zero=%b valid=%b expected 12/0/1", result, zero, out_valid);
    end
  endtask

  task automatic test_ops();
    logic [3:0]  ops  [7] = '{4'd0, 4'd1, 4'd2, 4'd4, 4'd6, 4'd7, 4'd12};
    logic [31:0] want [7] = '{32'h000000F0, 32'hFFFFF0FF, 32'hFFFFF1EF, 32'h00FF0000,
                              32'hE1E1EFF1, 32'h00000001, 32'h00000F00};
    logic [3:0]  bad  [2] = '{4'd9, 4'd15};
    for (int i = 0; i < 7; i++) begin
      drive_op(ops[i], 32'hF0F0F0F0, 32'h0F0F00FF);
      step();
      checks++;
      if (result !== want[i] || illegal !== 1'b0 || overflow !== 1'b0 || regwrite_out !== 1'b1) begin
        errors++; $display("FAIL op_%0d: result=%h ill=%b ov=%b rw=%b expected %h/0/0/1",
                           ops[i], result, illegal, overflow, regwrite_out, want[i]);
      end
    end
    for (int i = 0; i < 2; i++) begin
      drive_op(bad[i], 32'hF0F0F0F0, 32'h0F0F00FF);
      memwrite_in = 1'b1;
      step();
      checks++;
      if (illegal !== 1'b1 || result !== 32'd0 || regwrite_out !== 1'b0 || memwrite_out !== 1'b0 || zero !== 1'b1) begin
        errors++; $display("FAIL illegal_%0d: ill=%b result=%h rw=%b mw=%b zero=%b expected 1/0/0/0/1",
                           bad[i], illegal, result, regwrite_out, memwrite_out, zero);
      end
    end
  endtask

  task automatic test_overflow();
    drive_op(4'd2, 32'h7FFFFFFF, 32'd1);
    memwrite_in = 1'b1;
    step();
    checks++;
    if (result !== 32'h80000000 || overflow !== 1'b1 || regwrite_out !== 1'b0 || memwrite_out !== 1'b0) begin
      errors++; $display("FAIL add_overflow: result=%h ov=%b rw=%b mw=%b expected 80000000/1/0/0",
                         result, overflow, regwrite_out, memwrite_out);
    end
    drive_op(4'd6, 32'h80000000, 32'd1);
    step();
    checks++;
    if (result !== 32'h7FFFFFFF || overflow !== 1'b1 || regwrite_out !== 1'b0) begin
      errors++; $display("FAIL sub_overflow: result=%h ov=%b rw=%b expected 7fffffff/1/0", result, overflow, regwrite_out);
    end
    drive_op(4'd6, 32'd5, 32'd5);
    step();
    checks++;
    if (result !== 32'd0 || zero !== 1'b1 || overflow !== 1'b0 || regwrite_out !== 1'b1) begin
      errors++; $display("FAIL sub_zero: result=%h zero=%b ov=%b rw=%b expected 0/1/0/1", result, zero, overflow, regwrite_out);
    end
  endtask

  task automatic test_forwarding();
    drive_op(4'd2, 32'd1, 32'd55);
    exmem_data = 32'd100; memwb_data = 32'd200; fwd_a = 2'd2; fwd_b = 2'd1;
    step();
    checks++;
    if (result !== 32'd300 || store_data !== 32'd200) begin
      errors++; $display("FAIL fwd_reg_b: result=%0d store=%0d expected 300/200", result, store_data);
    end
    alusrc = 1'b1; imm = 32'd4;
    step();
    checks++;
    if (result !== 32'd104 || store_data !== 32'd200) begin
      errors++; $display("FAIL fwd_imm_b: result=%0d store=%0d expected 104/200", result, store_data);
    end
    drive_op(4'd2, 32'd1, 32'd2);
    fwd_a = 2'd3; fwd_b = 2'd3;
    step();
    checks++;
    if (result !== 32'd3 || store_data !== 32'd2) begin
      errors++; $display("FAIL fwd_sel3: result=%0d store=%0d expected 3/2", result, store_data);
    end
  endtask

  task automatic test_stall_flush();
    drive_op(4'd2, 32'd3, 32'd4);
    step();
    checks++;
    if (result !== 32'd7 || out_valid !== 1'b1) begin
      errors++; $display("FAIL stall_load: result=%0d valid=%b expected 7/1", result, out_valid);
    end
    for (int i = 0; i < 3; i++) begin
      drive_op(4'd6, $urandom, $urandom);
      in_valid = 1'($urandom); stall = 1'b1;
      step();
      checks++;
      if (result !== 32'd7 || out_valid !== 1'b1 || regwrite_out !== 1'b1) begin
        errors++; $display("FAIL stall_hold_%0d: result=%0d valid=%b rw=%b expected 7/1/1", i, result, out_valid, regwrite_out);
      end
    end
    stall = 1'b1; flush = 1'b1;
    step();
    checks++;
    if (out_valid !== 1'b0 || regwrite_out !== 1'b0) begin
      errors++; $display("FAIL stall_flush: valid=%b rw=%b expected 0/0", out_valid, regwrite_out);
    end
  endtask

  task automatic test_bubble();
    drive_op(4'd1, 32'h1234, 32'h5678);
    in_valid = 1'b0; memread_in = 1'b1; memwrite_in = 1'b1;
    step();
    checks++;
    if (out_valid !== 1'b0 || regwrite_out !== 1'b0 || memread_out !== 1'b0 || memwrite_out !== 1'b0 || result !== 32'd0) begin
      errors++; $display("FAIL bubble: valid=%b rw=%b mr=%b mw=%b result=%h expected all 0",
                         out_valid, regwrite_out, memread_out, memwrite_out, result);
    end
  endtask

  task automatic test_random();
    logic [3:0] codes [9] = '{4'd0, 4'd1, 4'd2, 4'd4, 4'd6, 4'd7, 4'd12, 4'd3, 4'd15};
    logic [31:0] edges [4] = '{32'h7FFFFFFF, 32'h80000000, 32'hFFFFFFFF, 32'h00000000};
    for (int i = 0; i < 400; i++) begin
      drive_op(codes[$urandom_range(0, 8)], $urandom, $urandom);
      if ($urandom_range(0, 3) == 0) a_val = edges[$urandom_range(0, 3)];
      if ($urandom_range(0, 3) == 0) b_val = edges[$urandom_range(0, 3)];
      if ($urandom_range(0, 5) == 0) b_val = a_val;
      reset = ($urandom_range(0, 40) == 0);
      in_valid = ($urandom_range(0, 7) != 0);
      stall = ($urandom_range(0, 4) == 0);
      flush = ($urandom_range(0, 9) == 0);
      alusrc = 1'($urandom);
      fwd_a = 2'($urandom); fwd_b = 2'($urandom);
      regwrite_in = 1'($urandom); memread_in = 1'($urandom); memwrite_in = 1'($urandom);
      step();
      checks++;
      if (obs !== exp_q) begin
        errors++; $display("FAIL random_%0d: got %h expected %h", i, obs, exp_q);
      end
    end
  endtask

  initial begin
    test_reset();
    test_ops();
    test_overflow();
    test_forwarding();
    test_stall_flush();
    test_bubble();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
